// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared AXI constants and write-engine state type for the DMA channel
package dmac_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    ADDR,
    DATA,
    DRAIN
  } wr_state_e;

endpackage

// File: rtl/dmac_wr_outstanding_ctr.sv
// rtl/dmac_wr_outstanding_ctr.sv - count of AW bursts still waiting for their B response
module dmac_wr_outstanding_ctr
  import dmac_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WD          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [CNT_WD-1:0] count,
  output logic              full,
  output logic              zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_WD'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNT_WD'(1);
    end
  end

  assign full = (count == CNT_WD'(MAX_OUTSTANDING));
  assign zero = (count == '0);

  // A B response with nothing outstanding is a slave protocol violation; the count holds at zero.
  no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && count == '0));

endmodule

// File: rtl/dmac_axi_wr_engine.sv
// rtl/dmac_axi_wr_engine.sv - drains the channel buffer into AXI4 INCR write bursts
module dmac_axi_wr_engine
  import dmac_pkg::*;
#(
  parameter int ADDR_WD         = 32,
  parameter int DATA_WD         = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int LEN_WD          = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [ADDR_WD-1:0]                cmd_addr,
  input  logic [LEN_WD-1:0]                 cmd_len,
  output logic                              done_valid,
  output logic                              done_err,
  input  logic [$clog2(MAX_BURST_LEN)+1:0]  buf_usage,
  output logic                              dec_usage_valid,
  output logic [$clog2(MAX_BURST_LEN)+1:0]  dec_usage_count,
  input  logic                              buf_rd_valid,
  output logic                              buf_rd_ready,
  input  logic [DATA_WD-1:0]                buf_rd_data,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [ADDR_WD-1:0]                m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  output logic [DATA_WD-1:0]                m_wdata,
  output logic [DATA_WD/8-1:0]              m_wstrb,
  output logic                              m_wlast,
  input  logic                              m_bvalid,
  output logic                              m_bready,
  input  logic [1:0]                        m_bresp
);

  localparam int USAGE_WD = $clog2(MAX_BURST_LEN) + 2;
  localparam int SIZE     = $clog2(DATA_WD / 8);
  localparam int CNT_WD   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [USAGE_WD-1:0] MAX_BEATS = USAGE_WD'(MAX_BURST_LEN);
  localparam logic [LEN_WD-1:0]   MAX_LEN   = LEN_WD'(MAX_BURST_LEN);

  wr_state_e             state;
  logic [ADDR_WD-1:0]    addr;
  logic [LEN_WD-1:0]     remaining;
  logic [USAGE_WD-1:0]   burst_beats;
  logic [USAGE_WD-1:0]   beat_cnt;
  logic [USAGE_WD-1:0]   next_beats;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  err;
  logic                  done_valid_r;
  logic                  done_err_r;
  logic [CNT_WD-1:0]     outstanding;
  logic                  ost_full;
  logic                  ost_zero;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  b_err;
  logic                  last_beat;
  logic                  drain_clear;

  assign next_beats  = (remaining >= MAX_LEN) ? MAX_BEATS : USAGE_WD'(remaining);
  assign aw_hs       = awvalid && m_awready;
  assign w_hs        = (state == DATA) && buf_rd_valid && m_wready;
  assign b_hs        = m_bvalid && m_bready;
  assign b_err       = b_hs && (m_bresp != RESP_OKAY);
  assign last_beat   = (beat_cnt == burst_beats - USAGE_WD'(1));
  // The final B may land in the same cycle the drain check is made.
  assign drain_clear = ost_zero || ((outstanding == CNT_WD'(1)) && b_hs);

  dmac_wr_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_WD          (CNT_WD)
  ) u_outstanding (
    .clk   (clk),
    .rst   (rst),
    .inc   (aw_hs),
    .dec   (b_hs),
    .count (outstanding),
    .full  (ost_full),
    .zero  (ost_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      burst_beats  <= '0;
      beat_cnt     <= '0;
      awlen        <= '0;
      awvalid      <= 1'b0;
      err          <= 1'b0;
      done_valid_r <= 1'b0;
      done_err_r   <= 1'b0;
    end else begin
      done_valid_r <= 1'b0;
      done_err_r   <= 1'b0;
      if (b_err) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            err       <= 1'b0;
            state     <= (cmd_len == '0) ? DRAIN : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // Only launch an address once the whole burst is already sitting in the buffer.
          if (buf_usage >= next_beats && !ost_full) begin
            burst_beats <= next_beats;
            awlen       <= 8'(next_beats - USAGE_WD'(1));
            awvalid     <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (m_awready) begin
            awvalid   <= 1'b0;
            addr      <= addr + (ADDR_WD'(burst_beats) << SIZE);
            remaining <= remaining - LEN_WD'(burst_beats);
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              state <= (remaining != '0) ? WAIT_DATA : DRAIN;
            end else begin
              beat_cnt <= beat_cnt + USAGE_WD'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_clear) begin
            done_valid_r <= 1'b1;
            done_err_r   <= err || b_err;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state == IDLE) && !rst;
  assign done_valid      = done_valid_r;
  assign done_err        = done_err_r;
  assign dec_usage_valid = aw_hs;
  assign dec_usage_count = aw_hs ? burst_beats : '0;

  assign m_awvalid = awvalid;
  assign m_awaddr  = addr;
  assign m_awlen   = awlen;
  assign m_awsize  = rst ? 3'd0 : 3'(SIZE);
  assign m_awburst = rst ? 2'b00 : BURST_INCR;

  assign m_wvalid     = (state == DATA) && buf_rd_valid;
  assign buf_rd_ready = (state == DATA) && m_wready;
  assign m_wdata      = (state == DATA) ? buf_rd_data : '0;
  assign m_wlast      = (state == DATA) && last_beat;
  assign m_wstrb      = rst ? '0 : '1;
  assign m_bready     = !rst;

endmodule

// File: tb/tb_dmac_axi_wr_engine.sv
// tb/tb_dmac_axi_wr_engine.sv - randomized bench with a burst-level model of the write engine
module tb_dmac_axi_wr_engine;

  localparam int ADDR_WD = 32;
  localparam int DATA_WD = 32;
  localparam int MBL     = 16;
  localparam int LEN_WD  = 16;
  localparam int MAXO    = 4;
  localparam int UW      = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               cmd_valid, cmd_ready;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [LEN_WD-1:0]  cmd_len;
  logic               done_valid, done_err;
  logic [UW-1:0]      buf_usage, dec_usage_count;
  logic               dec_usage_valid;
  logic               buf_rd_valid, buf_rd_ready;
  logic [DATA_WD-1:0] buf_rd_data;
  logic               m_awvalid, m_awready;
  logic [ADDR_WD-1:0] m_awaddr;
  logic [7:0]         m_awlen;
  logic [2:0]         m_awsize;
  logic [1:0]         m_awburst;
  logic               m_wvalid, m_wready, m_wlast;
  logic [DATA_WD-1:0] m_wdata;
  logic [3:0]         m_wstrb;
  logic               m_bvalid, m_bready;
  logic [1:0]         m_bresp;

  dmac_axi_wr_engine #(
    .ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .MAX_BURST_LEN(MBL),
    .LEN_WD(LEN_WD), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .done_valid(done_valid), .done_err(done_err),
    .buf_usage(buf_usage), .dec_usage_valid(dec_usage_valid), .dec_usage_count(dec_usage_count),
    .buf_rd_valid(buf_rd_valid), .buf_rd_ready(buf_rd_ready), .buf_rd_data(buf_rd_data),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  typedef struct { logic [31:0] addr; int beats; } aw_t;
  typedef struct { int beats; int idx; } wb_t;
  typedef struct { logic [31:0] addr; int len; int dec; } log_t;

  aw_t         exp_aw[$];
  wb_t         w_bursts[$];
  log_t        aw_log[$];
  logic [31:0] buf_q[$];
  logic [1:0]  b_q[$];

  int checks = 0;
  int passed = 0;
  int cycle = 0;
  int unreserved = 0, fill_left = 0;
  int fill_pct = 100, rdv_pct = 100, awr_pct = 100, wr_pct = 100, b_pct = 100;
  int outstanding = 0, w_idx = 0, burst_ctr = 0, cur_err_burst = -1;
  int nb_exp = 0, bs_cmd = 0, w_cmd = 0, done_count = 0, last_evt = 0;
  int first_aw = -1, track_level = 0, track_cycle = -1;
  bit exp_err, done_pending, prev_done, mon_en, last_done_err;
  bit aw_hs, w_hs, b_hs, rd_hs;
  aw_t         mon_e;
  logic [31:0] word;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Buffer and AXI slave: inputs change only just after the rising edge.
  initial begin
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; buf_usage = 0; buf_rd_valid = 0; buf_rd_data = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    forever begin
      @(posedge clk); #1;
      if (fill_left > 0 && int'($urandom_range(0, 99)) < fill_pct) begin
        word = $urandom;
        buf_q.push_back(word);
        unreserved++;
        fill_left--;
      end
      if (track_cycle < 0 && track_level > 0 && unreserved >= track_level) track_cycle = cycle;
      buf_usage    = UW'(unreserved);
      buf_rd_valid = (buf_q.size() > 0) && (int'($urandom_range(0, 99)) < rdv_pct);
      buf_rd_data  = (buf_q.size() > 0) ? buf_q[0] : $urandom;
      m_awready    = int'($urandom_range(0, 99)) < awr_pct;
      m_wready     = int'($urandom_range(0, 99)) < wr_pct;
      m_bvalid     = (b_q.size() > 0) && (int'($urandom_range(0, 99)) < b_pct);
      m_bresp      = (b_q.size() > 0) ? b_q[0] : 2'b00;
    end
  end

  // Compare process: burst-level expectations checked at the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      b_hs  = m_bvalid && m_bready;
      rd_hs = buf_rd_valid && buf_rd_ready;
      if (aw_hs || dec_usage_valid) chk("dec_pulse", dec_usage_valid, aw_hs);
      if (aw_hs) begin
        if (first_aw < 0) first_aw = cycle;
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else begin
          mon_e = exp_aw.pop_front();
          chk("awaddr", m_awaddr, mon_e.addr);
          chk("awlen", m_awlen, mon_e.beats - 1);
          chk("dec_count", dec_usage_count, mon_e.beats);
          chk("aw_data_present", unreserved >= mon_e.beats, 1);
          chk("aw_outstanding", outstanding < MAXO, 1);
          chk("aw_w_overlap", w_bursts.size(), 0);
          chk("awsize", m_awsize, 2);
          chk("awburst", m_awburst, 1);
          chk("wstrb", m_wstrb, 4'hf);
          aw_log.push_back('{m_awaddr, int'(m_awlen), int'(dec_usage_count)});
          unreserved -= mon_e.beats;
          w_bursts.push_back('{mon_e.beats, burst_ctr});
          burst_ctr++;
          outstanding++;
        end
      end
      if (rd_hs || w_hs) chk("rd_w_handshake", rd_hs, w_hs);
      if (w_hs) begin
        w_cmd++;
        if (w_bursts.size() == 0) chk("w_before_aw", 0, 1);
        else begin
          if (buf_q.size() > 0) chk("wdata", m_wdata, buf_q[0]);
          else chk("wdata_empty_buffer", 0, 1);
          chk("wlast", m_wlast, w_idx == w_bursts[0].beats - 1);
          if (w_idx == w_bursts[0].beats - 1) begin
            b_q.push_back((w_bursts[0].idx == cur_err_burst) ? 2'b10 : 2'b00);
            void'(w_bursts.pop_front());
            w_idx = 0;
          end else w_idx++;
        end
      end
      if (rd_hs && buf_q.size() > 0) void'(buf_q.pop_front());
      if (b_hs && b_q.size() > 0) begin
        void'(b_q.pop_front());
        outstanding--;
        bs_cmd++;
        last_evt = cycle;
      end
      if (cmd_valid && cmd_ready) begin
        done_pending = 1;
        last_evt = cycle;
      end
      if (done_valid) begin
        chk("done_expected", done_pending, 1);
        chk("done_all_b", bs_cmd, nb_exp);
        chk("done_all_aw", exp_aw.size(), 0);
        chk("done_err", done_err, exp_err);
        chk("done_latency", (cycle - last_evt) <= 2, 1);
        chk("done_one_cycle", prev_done, 0);
        last_done_err = done_err;
        done_pending = 0;
        done_count++;
      end
      prev_done = done_valid;
    end
  end

  task automatic send_cmd(input logic [31:0] addr, input int len);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_addr = addr; cmd_len = LEN_WD'(len);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk("cmd_accept", ok, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic setup_cmd(input logic [31:0] addr, input int len, input int err_burst);
    int rem = len;
    int nb = 0;
    logic [31:0] a = addr;
    exp_aw.delete();
    aw_log.delete();
    while (rem > 0) begin
      int b = (rem > MBL) ? MBL : rem;
      exp_aw.push_back('{a, b});
      a += 32'(b * (DATA_WD / 8));
      rem -= b;
      nb++;
    end
    nb_exp = nb;
    exp_err = (err_burst >= 0) && (err_burst < nb);
    cur_err_burst = err_burst;
    burst_ctr = 0; bs_cmd = 0; w_cmd = 0; first_aw = -1;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int len, input int err_burst, input int fill_words);
    int start_done;
    bit ok = 0;
    setup_cmd(addr, len, err_burst);
    fill_left += fill_words;
    start_done = done_count;
    send_cmd(addr, len);
    for (int i = 0; i < 5000; i++) begin
      if (done_count != start_done) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("done_timeout", ok, 1);
  endtask

  task automatic set_rates(input int f, input int rv, input int ar, input int wr, input int bp);
    fill_pct = f; rdv_pct = rv; awr_pct = ar; wr_pct = wr; b_pct = bp;
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_dec_valid", dec_usage_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_rd_ready", buf_rd_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_bready", m_bready, 1);
    mon_en = 1;

    // single full burst
    set_rates(100, 100, 100, 100, 100);
    run_cmd(32'h1000, 16, -1, 16);
    chk("t1_aw_count", aw_log.size(), 1);
    if (aw_log.size() == 1) begin
      chk("t1_awaddr", aw_log[0].addr, 32'h1000);
      chk("t1_awlen", aw_log[0].len, 15);
      chk("t1_dec", aw_log[0].dec, 16);
    end
    chk("t1_beats", w_cmd, 16);
    chk("t1_done_err", last_done_err, 0);

    // multi-burst with a tail
    run_cmd(32'h1000, 40, -1, 40);
    chk("t2_aw_count", aw_log.size(), 3);
    if (aw_log.size() == 3) begin
      chk("t2_aw0", {aw_log[0].addr, 8'(aw_log[0].len), 8'(aw_log[0].dec)}, {32'h1000, 8'd15, 8'd16});
      chk("t2_aw1", {aw_log[1].addr, 8'(aw_log[1].len), 8'(aw_log[1].dec)}, {32'h1040, 8'd15, 8'd16});
      chk("t2_aw2", {aw_log[2].addr, 8'(aw_log[2].len), 8'(aw_log[2].dec)}, {32'h1080, 8'd7, 8'd8});
    end
    chk("t2_b_count", bs_cmd, 3);

    // not enough data buffered
    fill_left = 10;
    repeat (14) @(posedge clk);
    chk("t3_preload", unreserved, 10);
    track_level = 0; track_cycle = -1;
    fork
      run_cmd(32'h1000, 16, -1, 0);
      begin
        repeat (30) @(negedge clk);
        chk("t3_no_aw_short", first_aw, -1);
        chk("t3_awvalid_low", m_awvalid, 0);
        track_level = 16;
        fill_left = 6;
        for (int i = 0; i < 200 && first_aw < 0; i++) @(negedge clk);
        chk("t3_aw_latency", first_aw, track_cycle + 1);
        track_level = 0;
      end
    join

    // W backpressure
    set_rates(100, 50, 100, 50, 100);
    run_cmd(32'h2000, 16, -1, 16);
    chk("t4_beats", w_cmd, 16);

    // SLVERR on the second of three bursts, then a clean command
    set_rates(100, 100, 100, 100, 60);
    run_cmd(32'h3000, 40, 1, 40);
    chk("t5_done_err", last_done_err, 1);
    chk("t5_b_count", bs_cmd, 3);
    run_cmd(32'h4000, 16, -1, 16);
    chk("t6_done_err_cleared", last_done_err, 0);

    // zero-length command
    run_cmd(32'h5000, 0, -1, 0);
    chk("t7_no_aw", aw_log.size(), 0);

    // randomized commands
    for (int k = 0; k < 8; k++) begin
      int len = int'($urandom_range(1, 60));
      int eb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      set_rates(int'($urandom_range(20, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(5, 100)));
      run_cmd(32'($urandom_range(0, 4000)) * 32'd64, len, eb, len);
    end

    // reset in the middle of a data burst
    set_rates(100, 100, 100, 20, 100);
    setup_cmd(32'h6000, 16, -1);
    fill_left = 16;
    send_cmd(32'h6000, 16);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_wvalid) begin seen = 1; break; end
    end
    chk("t9_reached_data", seen, 1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("t9_wvalid", m_wvalid, 0);
    chk("t9_rd_ready", buf_rd_ready, 0);
    chk("t9_wlast", m_wlast, 0);
    chk("t9_wdata", m_wdata, 0);
    chk("t9_awvalid", m_awvalid, 0);
    chk("t9_cmd_ready", cmd_ready, 0);
    chk("t9_bready", m_bready, 0);
    chk("t9_done", done_valid, 0);
    buf_q.delete(); b_q.delete(); exp_aw.delete(); w_bursts.delete();
    unreserved = 0; fill_left = 0; w_idx = 0; outstanding = 0;
    done_pending = 0; prev_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t9_cmd_ready_after", cmd_ready, 1);

    // recovery after reset
    set_rates(100, 100, 100, 100, 100);
    run_cmd(32'h7000, 20, -1, 20);
    chk("t10_aw_count", aw_log.size(), 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
